// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte-enabled word RAM with configurable access latency.
// Legal requests stall the pipeline until the access completes; bad requests pulse misalign/fault.
module mem_stage_lsu #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_req_valid_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [2:0]            MEM_funct3_i,
  input  logic [DATA_WIDTH-1:0] MEM_addr_i,
  input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
  output logic                  MEM_stall_o,
  output logic [DATA_WIDTH-1:0] MEM_rd_data_o,
  output logic                  MEM_rd_valid_o,
  output logic                  MEM_misalign_o,
  output logic                  MEM_fault_o
);

  // state | meaning
  // IDLE  | decoding requests; a legal one raises stall combinationally (cycle 0)
  // BUSY  | access in flight; counter tracks the current cycle number
  // RESP  | access done; load result presented, stall released, inputs ignored
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAST    = 4'(MEM_LATENCY - 1);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_f3;
  logic        r_we;
  logic [31:0] r_rd_data;
  logic        r_rd_valid, r_misalign, r_fault;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_idle, w_req, w_f3_ok, w_illegal, w_misal, w_oor, w_legal;
  logic        w_rej_misal, w_rej_fault, w_commit, w_stall;
  logic [31:0] w_off;
  logic [31:0] w_acc_addr, w_acc_wdata, w_acc_off, w_rword, w_load, w_wword;
  logic [2:0]  w_acc_f3;
  logic        w_acc_we;
  logic [AW-1:0] w_idx;
  logic [15:0] w_lane;
  logic [3:0]  w_be;

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = MEM_req_valid_i & (MEM_MemRead_i | MEM_MemWrite_i);

  always_comb begin
    w_f3_ok = 1'b0;
    case (MEM_funct3_i)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = MEM_MemRead_i;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  // An illegal encoding has no meaningful width, so it is never reported as misaligned.
  assign w_illegal = (MEM_MemRead_i & MEM_MemWrite_i) | ~w_f3_ok;
  assign w_misal   = ((MEM_funct3_i[1:0] == 2'b01) & MEM_addr_i[0]) |
                     ((MEM_funct3_i[1:0] == 2'b10) & (MEM_addr_i[1:0] != 2'b00));
  assign w_off     = MEM_addr_i - BASE_ADDR;
  assign w_oor     = (MEM_addr_i < BASE_ADDR) | ((w_off >> 2) >= DEPTH32);

  assign w_legal     = w_req & ~w_illegal & ~w_misal & ~w_oor;
  assign w_rej_misal = w_req & ~w_illegal & w_misal;
  assign w_rej_fault = w_req & (w_illegal | (~w_misal & w_oor));

  // With MEM_LATENCY=1 the access completes on the acceptance edge, straight from the inputs.
  assign w_commit = (w_idle & w_legal & (MEM_LATENCY == 1)) |
                    ((r_state == S_BUSY) & (r_cnt == LAST));

  assign w_acc_addr  = w_idle ? MEM_addr_i     : r_addr;
  assign w_acc_wdata = w_idle ? MEM_wr_data_i  : r_wdata;
  assign w_acc_f3    = w_idle ? MEM_funct3_i   : r_f3;
  assign w_acc_we    = w_idle ? MEM_MemWrite_i : r_we;
  assign w_acc_off   = w_acc_addr - BASE_ADDR;
  assign w_idx       = AW'(w_acc_off >> 2);
  assign w_rword     = r_mem[w_idx];

  always_comb begin
    w_lane = 16'(w_rword >> {w_acc_addr[1:0], 3'b000});
    case (w_acc_f3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {24'h0, w_lane[7:0]};
      3'b101:  w_load = {16'h0, w_lane[15:0]};
      default: w_load = w_rword;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wword = w_acc_wdata;
    case (w_acc_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_acc_addr[1:0];
        w_wword = {4{w_acc_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{w_acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_legal;
        if (w_legal) w_next = (MEM_LATENCY == 1) ? S_RESP : S_BUSY;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == LAST) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_rd_data  <= 32'h0;
      r_rd_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_misalign <= w_idle & w_rej_misal;
      r_fault    <= w_idle & w_rej_fault;
      r_rd_valid <= w_commit & ~w_acc_we;
      if (w_commit & ~w_acc_we) r_rd_data <= w_load;
      if (w_idle & w_legal)          r_cnt <= 4'd1;
      else if (r_state == S_BUSY)    r_cnt <= r_cnt + 4'd1;
      else                           r_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_idle & w_legal) begin
      r_addr  <= MEM_addr_i;
      r_wdata <= MEM_wr_data_i;
      r_f3    <= MEM_funct3_i;
      r_we    <= MEM_MemWrite_i;
    end
  end

  // RAM contents survive reset, but a store whose commit edge sees rst is dropped.
  always_ff @(posedge clk) begin
    if (w_commit & w_acc_we & ~rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  assign MEM_stall_o    = w_stall & ~rst;
  assign MEM_rd_data_o  = r_rd_data;
  assign MEM_rd_valid_o = r_rd_valid;
  assign MEM_misalign_o = r_misalign;
  assign MEM_fault_o    = r_fault;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset-abort and latency-1
// sequences, and randomized traffic checked against a byte-array memory model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_valid, a_rd, a_wr;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_stall, a_rvalid, a_mis, a_flt;

  logic        b_valid, b_rd, b_wr;
  logic [2:0]  b_f3;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_stall, b_rvalid, b_mis, b_flt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem_b [0:4095];
  logic [31:0] m_rd;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, data;
    int          stall, vld;
    logic [31:0] rdd;
    int          mis, flt;
  } vec_t;

  vec_t tv[$];

  always #5 clk = ~clk;

  mem_stage_lsu #(.MEM_LATENCY(2)) u_a (
    .clk(clk), .rst(rst),
    .MEM_req_valid_i(a_valid), .MEM_MemRead_i(a_rd), .MEM_MemWrite_i(a_wr),
    .MEM_funct3_i(a_f3), .MEM_addr_i(a_addr), .MEM_wr_data_i(a_wdata),
    .MEM_stall_o(a_stall), .MEM_rd_data_o(a_rdata), .MEM_rd_valid_o(a_rvalid),
    .MEM_misalign_o(a_mis), .MEM_fault_o(a_flt)
  );

  mem_stage_lsu #(.DEPTH_WORDS(16), .MEM_LATENCY(1), .BASE_ADDR(32'h100)) u_b (
    .clk(clk), .rst(rst),
    .MEM_req_valid_i(b_valid), .MEM_MemRead_i(b_rd), .MEM_MemWrite_i(b_wr),
    .MEM_funct3_i(b_f3), .MEM_addr_i(b_addr), .MEM_wr_data_i(b_wdata),
    .MEM_stall_o(b_stall), .MEM_rd_data_o(b_rdata), .MEM_rd_valid_o(b_rvalid),
    .MEM_misalign_o(b_mis), .MEM_fault_o(b_flt)
  );

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int stall, input int vld, input logic [31:0] rdd,
                              input int mis, input int flt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.data = data;
    v.stall = stall; v.vld = vld; v.rdd = rdd; v.mis = mis; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    if (sel) begin
      b_valid = v; b_rd = rd; b_wr = wr; b_f3 = f3; b_addr = addr; b_wdata = d;
    end else begin
      a_valid = v; a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = addr; a_wdata = d;
    end
  endtask

  // Presents one instruction like a stage register would: held while stall is high,
  // and for the cycle in which stall is seen low, then replaced by a bubble.
  task automatic run_op(input bit sel, input logic v, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d,
                        output int ns, output int nv, output int nm, output int nf,
                        output logic [31:0] last_rd);
    logic drop;
    ns = 0; nv = 0; nm = 0; nf = 0;
    drive(sel, v, rd, wr, f3, addr, d);
    for (int c = 0; c < 7; c++) begin
      #2;
      if (sel ? b_stall  : a_stall)  ns++;
      if (sel ? b_rvalid : a_rvalid) nv++;
      if (sel ? b_mis    : a_mis)    nm++;
      if (sel ? b_flt    : a_flt)    nf++;
      drop = !(sel ? b_stall : a_stall);
      @(posedge clk); #1;
      if (drop) drive(sel, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    end
    last_rd = sel ? b_rdata : a_rdata;
  endtask

  task automatic op_check(input string nm, input bit sel, input logic v, input logic rd,
                          input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] d, input int es, input int ev,
                          input logic [31:0] erd, input int em, input int ef);
    int ns, nv, nmis, nf;
    logic [31:0] ard;
    run_op(sel, v, rd, wr, f3, addr, d, ns, nv, nmis, nf, ard);
    chk({nm, " stall_cycles"}, 32'(ns), 32'(es));
    chk({nm, " rd_valid_pulses"}, 32'(nv), 32'(ev));
    chk({nm, " rd_data"}, ard, erd);
    chk({nm, " misalign_pulses"}, 32'(nmis), 32'(em));
    chk({nm, " fault_pulses"}, 32'(nf), 32'(ef));
  endtask

  // Reference classification for the latency-2 unit (base 0, 1024 words):
  // 0 legal, 1 misaligned, 2 fault, 3 no request.
  function automatic int classify(input logic v, input logic rd, input logic wr,
                                  input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] size;
    if (!v || !(rd || wr)) return 3;
    if (rd && wr) return 2;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 2;
    size = 32'd1 << f3[1:0];
    if ((addr % size) != 0) return 1;
    if ((addr / 4) >= 1024) return 2;
    return 0;
  endfunction

  task automatic model_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] d,
                          output int cls, output logic [31:0] exp_rd);
    int size;
    longint val;
    cls  = classify(v, rd, wr, f3, addr);
    size = 1 << f3[1:0];
    if (cls == 0 && wr)
      for (int i = 0; i < size; i++) mem_b[addr + 32'(i)] = 8'(d >> (8 * i));
    if (cls == 0 && rd) begin
      val = 0;
      for (int i = size - 1; i >= 0; i--) val = val * 256 + longint'(mem_b[addr + 32'(i)]);
      if (!f3[2] && val >= (64'sd1 << (8 * size - 1))) val = val - (64'sd1 << (8 * size));
      m_rd = 32'(val);
    end
    exp_rd = m_rd;
  endtask

  initial begin : main
    int cls;
    logic [31:0] erd, addr, d;
    logic v, rd, wr;
    logic [2:0] f3;
    int k, p;
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

    tv.push_back(mk(0,1,3'd2,32'h10,  32'hDEADBEEF, 2,0,32'h00000000,0,0));
    tv.push_back(mk(1,0,3'd2,32'h10,  32'h0,        2,1,32'hDEADBEEF,0,0));
    tv.push_back(mk(0,1,3'd0,32'h13,  32'h00000080, 2,0,32'hDEADBEEF,0,0));
    tv.push_back(mk(1,0,3'd0,32'h13,  32'h0,        2,1,32'hFFFFFF80,0,0));
    tv.push_back(mk(1,0,3'd4,32'h13,  32'h0,        2,1,32'h00000080,0,0));
    tv.push_back(mk(1,0,3'd2,32'h10,  32'h0,        2,1,32'h80ADBEEF,0,0));
    tv.push_back(mk(1,0,3'd1,32'h11,  32'h0,        0,0,32'h80ADBEEF,1,0));
    tv.push_back(mk(1,0,3'd2,32'h10,  32'h0,        2,1,32'h80ADBEEF,0,0));
    tv.push_back(mk(1,0,3'd2,32'h1000,32'h0,        0,0,32'h80ADBEEF,0,1));
    tv.push_back(mk(1,0,3'd3,32'h10,  32'h0,        0,0,32'h80ADBEEF,0,1));
    tv.push_back(mk(1,1,3'd2,32'h10,  32'h0,        0,0,32'h80ADBEEF,0,1));
    tv.push_back(mk(0,1,3'd1,32'h12,  32'hFFFF8001, 2,0,32'h80ADBEEF,0,0));
    tv.push_back(mk(1,0,3'd1,32'h12,  32'h0,        2,1,32'hFFFF8001,0,0));
    tv.push_back(mk(1,0,3'd5,32'h12,  32'h0,        2,1,32'h00008001,0,0));
    tv.push_back(mk(0,1,3'd2,32'h20,  32'h5555AAAA, 2,0,32'h00008001,0,0));
    tv.push_back(mk(0,1,3'd2,32'hFFC, 32'h0BADF00D, 2,0,32'h00008001,0,0));
    tv.push_back(mk(1,0,3'd2,32'hFFC, 32'h0,        2,1,32'h0BADF00D,0,0));
    tv.push_back(mk(0,1,3'd4,32'h10,  32'h0,        0,0,32'h0BADF00D,0,1));
    tv.push_back(mk(0,1,3'd2,32'h22,  32'h0,        0,0,32'h0BADF00D,1,0));
    tv.push_back(mk(1,0,3'd2,32'h1002,32'h0,        0,0,32'h0BADF00D,1,0));
    tv.push_back(mk(1,0,3'd0,32'h11,  32'h0,        2,1,32'hFFFFFFBE,0,0));
    tv.push_back(mk(0,1,3'd0,32'h10,  32'h0000007F, 2,0,32'hFFFFFFBE,0,0));
    tv.push_back(mk(1,0,3'd0,32'h10,  32'h0,        2,1,32'h0000007F,0,0));
    tv.push_back(mk(1,0,3'd2,32'h20,  32'h0,        2,1,32'h5555AAAA,0,0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 3'd0, 32'h0, 32'h0);
    m_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("reset stall",    32'(a_stall),  32'h0);
    chk("reset rd_data",  a_rdata,       32'h0);
    chk("reset rd_valid", 32'(a_rvalid), 32'h0);
    chk("reset misalign", 32'(a_mis),    32'h0);
    chk("reset fault",    32'(a_flt),    32'h0);
    chk("reset b rd_data", b_rdata,      32'h0);
    @(posedge clk); #1;

    foreach (tv[i]) begin
      model_op(1'b1, tv[i].rd, tv[i].wr, tv[i].f3, tv[i].addr, tv[i].data, cls, erd);
      op_check($sformatf("vec%0d", i), 1'b0, 1'b1, tv[i].rd, tv[i].wr, tv[i].f3,
               tv[i].addr, tv[i].data, tv[i].stall, tv[i].vld, tv[i].rdd, tv[i].mis, tv[i].flt);
    end

    // Reset lands in the commit cycle of a store: nothing written, everything cleared.
    drive(0, 1, 0, 1, 3'd2, 32'h20, 32'h00001234);
    #2;
    chk("rstbusy stall_c0", 32'(a_stall), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 3'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("rstbusy stall",    32'(a_stall),  32'h0);
    chk("rstbusy rd_data",  a_rdata,       32'h0);
    chk("rstbusy rd_valid", 32'(a_rvalid), 32'h0);
    chk("rstbusy misalign", 32'(a_mis),    32'h0);
    chk("rstbusy fault",    32'(a_flt),    32'h0);
    @(posedge clk); #1;
    m_rd = 32'h0;
    model_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0, cls, erd);
    op_check("rstbusy reload", 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 2, 1, 32'h5555AAAA, 0, 0);

    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      model_op(1'b1, 1'b0, 1'b1, 3'd2, 32'(w * 4), d, cls, erd);
      op_check($sformatf("fill%0d", w), 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 32'(w * 4), d,
               2, 0, erd, 0, 0);
    end

    for (int n = 0; n < 150; n++) begin
      v  = ($urandom_range(0, 19) != 0);
      k  = int'($urandom_range(0, 9));
      rd = (k < 5) || (k == 8);
      wr = (k >= 5 && k < 8) || (k == 8);
      if ($urandom_range(0, 4) != 0)
        f3 = rd ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      else
        f3 = 3'($urandom_range(0, 7));
      p = int'($urandom_range(0, 9));
      if (p < 8)       addr = 32'($urandom_range(0, 255));
      else if (p == 8) addr = 32'($urandom_range(4096, 4200));
      else             addr = $urandom;
      if ($urandom_range(0, 1) != 0) addr = addr & 32'hFFFF_FFFC;
      d = $urandom;
      model_op(v, rd, wr, f3, addr, d, cls, erd);
      op_check($sformatf("rand%0d", n), 1'b0, v, rd, wr, f3, addr, d,
               (cls == 0) ? 2 : 0, (cls == 0 && rd) ? 1 : 0, erd,
               (cls == 1) ? 1 : 0, (cls == 2) ? 1 : 0);
    end

    // Latency-1 unit at base 0x100, 16 words; loads stay on the inputs through RESP.
    op_check("l1 sw",        1'b1, 1, 0, 1, 3'd2, 32'h104, 32'hCAFEF00D, 1, 0, 32'h0, 0, 0);
    op_check("l1 lw",        1'b1, 1, 1, 0, 3'd2, 32'h104, 32'h0, 1, 1, 32'hCAFEF00D, 0, 0);
    op_check("l1 below",     1'b1, 1, 1, 0, 3'd2, 32'h0FC, 32'h0, 0, 0, 32'hCAFEF00D, 0, 1);
    op_check("l1 above",     1'b1, 1, 1, 0, 3'd2, 32'h140, 32'h0, 0, 0, 32'hCAFEF00D, 0, 1);
    op_check("l1 sw_last",   1'b1, 1, 0, 1, 3'd2, 32'h13C, 32'h11223344, 1, 0, 32'hCAFEF00D, 0, 0);
    op_check("l1 lhu_last",  1'b1, 1, 1, 0, 3'd5, 32'h13E, 32'h0, 1, 1, 32'h00001122, 0, 0);
    op_check("l1 lb_last",   1'b1, 1, 1, 0, 3'd0, 32'h13C, 32'h0, 1, 1, 32'h00000044, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
